// File: rtl/sweep_ctrl_3_32_e.sv
// Self-test sequencer for F = (A+B)(C+D)E: sweeps all 32 vectors,
// holds each SETTLE+1 cycles and scores the sampled F against golden.
//
// Ports:
//   Clock, Reset_b      rising-edge clock, async active-low reset
//   start, abort        sweep request (IDLE only), cancel (WAIT only)
//   f_in                F output of the network under test
//   vec                 applied vector {A,B,C,D,E}
//   busy, done, pass    sweep status; done is a one-cycle pulse
//   ones_count          sampled vectors with f_in=1
//   err_count           sampled vectors with f_in != golden
//   err_flag            first-mismatch marker
//   first_err_vec       vector of the first mismatch (0 if none)
module sweep_ctrl_3_32_e #(
    parameter int unsigned SETTLE = 0
) (
    input  logic       Clock,
    input  logic       Reset_b,
    input  logic       start,
    input  logic       abort,
    input  logic       f_in,
    output logic [4:0] vec,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [5:0] ones_count,
    output logic [5:0] err_count,
    output logic       err_flag,
    output logic [4:0] first_err_vec
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    localparam logic [3:0] SET = 4'(SETTLE);

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [4:0] vec_n, fev_n;
    logic [5:0] ones_n, err_n;
    logic       busy_n, done_n, pass_n, flag_n;
    logic       golden;

    assign golden = (vec[4] | vec[3]) & (vec[2] | vec[1]) & vec[0];

    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) begin
            state         <= IDLE;
            cnt           <= '0;
            vec           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            ones_count    <= '0;
            err_count     <= '0;
            err_flag      <= 1'b0;
            first_err_vec <= '0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            vec           <= vec_n;
            busy          <= busy_n;
            done          <= done_n;
            pass          <= pass_n;
            ones_count    <= ones_n;
            err_count     <= err_n;
            err_flag      <= flag_n;
            first_err_vec <= fev_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        vec_n   = vec;
        busy_n  = busy;
        done_n  = 1'b0;
        pass_n  = pass;
        ones_n  = ones_count;
        err_n   = err_count;
        flag_n  = err_flag;
        fev_n   = first_err_vec;

        unique case (state)
            IDLE: begin
                if (start) begin
                    ones_n  = '0;
                    err_n   = '0;
                    flag_n  = 1'b0;
                    fev_n   = '0;
                    pass_n  = 1'b0;
                    vec_n   = '0;
                    cnt_n   = SET;
                    busy_n  = 1'b1;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                // Abort wins over the sample in the same cycle.
                if (abort) begin
                    busy_n  = 1'b0;
                    vec_n   = '0;
                    state_n = IDLE;
                end else if (cnt != 4'd0) begin
                    cnt_n = cnt - 4'd1;
                end else begin
                    ones_n = ones_count + {5'd0, f_in};
                    if (f_in != golden) begin
                        err_n = err_count + 6'd1;
                        if (!err_flag) begin
                            flag_n = 1'b1;
                            fev_n  = vec;
                        end
                    end
                    if (vec == 5'd31) begin
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        pass_n  = (err_n == 6'd0);
                        state_n = DONE;
                    end else begin
                        vec_n = vec + 5'd1;
                        cnt_n = SET;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
